// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the vectored priority interrupt controller:
// register map, FSM state encoding, STATUS layout and the vector formula.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_PEND   = 3'd0;
    localparam logic [2:0] IRQ_MASK   = 3'd1;
    localparam logic [2:0] IRQ_MODE   = 3'd2;
    localparam logic [2:0] IRQ_VBASE  = 3'd3;
    localparam logic [2:0] IRQ_STATUS = 3'd4;
    localparam logic [2:0] IRQ_EOI    = 3'd5;

    localparam int STAT_INSVC_BIT = 7;
    localparam int STAT_REQ_BIT   = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Vectors are spaced two bytes apart and wrap modulo 256.
    function automatic logic [7:0] calc_vector(input logic [7:0] vbase,
                                               input logic [2:0] idx);
        return vbase + {4'b0000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder: reports whether any request is set
// and the index of the lowest set bit.
module prio_enc8 (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_o = |req_i;
        idx_o   = 3'd0;
        // Scanning downward makes the lowest set bit the final assignment.
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored priority interrupt controller: latches and masks peripheral request
// lines, raises a single CPU request, supplies a vector on acknowledge.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic             wb_clk_i,
    input  logic             rst,
    input  logic             bus_cyc,
    input  logic             bus_we,
    input  logic [2:0]       addr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             int_ack,
    output logic             int_req,
    output logic [7:0]       int_vector
);

    // Bits at or above N_IRQ never hold state and always read back as 0.
    localparam logic [7:0] LINE_MASK = 8'((16'd1 << N_IRQ) - 16'd1);

    logic [7:0] pend_q,     pend_d;
    logic [7:0] mask_q,     mask_d;
    logic [7:0] mode_q,     mode_d;
    logic [7:0] vbase_q,    vbase_d;
    logic [7:0] irq_prev_q, irq_prev_d;
    logic [2:0] isr_idx_q,  isr_idx_d;
    irq_state_t state_q,    state_d;

    logic [7:0] irq_ext;
    logic [7:0] active;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] status;
    logic       win_valid;
    logic [2:0] win_idx;
    logic       wr_en;
    logic       ack_take;
    logic       eoi_wr;
    logic       in_svc;

    always_comb begin
        irq_ext              = 8'h00;
        irq_ext[N_IRQ-1:0]   = irq_in;
    end

    assign wr_en    = bus_cyc && bus_we;
    assign active   = pend_q & mask_q;
    assign ack_take = (state_q == REQ) && int_ack;
    assign eoi_wr   = wr_en && (addr == IRQ_EOI);
    assign in_svc   = (state_q == SERVICE);

    prio_enc8 u_prio (
        .req_i   (active),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        isr_idx_d = isr_idx_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Acknowledge takes precedence over the active set emptying.
                if (ack_take) begin
                    state_d   = SERVICE;
                    isr_idx_d = win_idx;
                end else if (!win_valid) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rise = irq_ext & ~irq_prev_q;
        clr  = 8'h00;
        if (wr_en && (addr == IRQ_PEND)) begin
            clr = data_in;
        end
        if (ack_take && win_valid) begin
            clr[win_idx] = 1'b1;
        end
        // Clear is applied before the new edge is ORed in, so a fresh edge
        // always survives a same-cycle W1C or acknowledge.
        pend_d = ((mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & irq_ext))
                 & LINE_MASK;

        irq_prev_d = irq_ext;
        mask_d     = mask_q;
        mode_d     = mode_q;
        vbase_d    = vbase_q;
        if (wr_en) begin
            unique case (addr)
                IRQ_MASK:  mask_d  = data_in & LINE_MASK;
                IRQ_MODE:  mode_d  = data_in & LINE_MASK;
                IRQ_VBASE: vbase_d = data_in;
                default:   ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (!rst) begin
            pend_q     <= 8'h00;
            mask_q     <= 8'h00;
            mode_q     <= 8'h00;
            vbase_q    <= 8'h00;
            irq_prev_q <= 8'h00;
            isr_idx_q  <= 3'd0;
            state_q    <= IDLE;
        end else begin
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            vbase_q    <= vbase_d;
            irq_prev_q <= irq_prev_d;
            isr_idx_q  <= isr_idx_d;
            state_q    <= state_d;
        end
    end

    assign int_req    = (state_q == REQ);
    assign int_vector = (int_req && win_valid) ? calc_vector(vbase_q, win_idx) : 8'h00;

    always_comb begin
        status                 = 8'h00;
        status[STAT_INSVC_BIT] = in_svc;
        status[STAT_REQ_BIT]   = int_req;
        if (in_svc) begin
            status[2:0] = isr_idx_q;
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (addr)
            IRQ_PEND:   data_out = pend_q;
            IRQ_MASK:   data_out = mask_q;
            IRQ_MODE:   data_out = mode_q;
            IRQ_VBASE:  data_out = vbase_q;
            IRQ_STATUS: data_out = status;
            default:    data_out = 8'h00;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Vectored priority interrupt controller on the AS2650 peripheral bus. It collects the peripheral interrupt lines (gpios, timers, serial_ports), latches and masks them, and drives the CPU's single interrupt request. On CPU acknowledge it supplies a vector byte, then holds the request off until software writes end-of-interrupt. It is a bus slave beside gpios, timers and serial_ports, selected by its own `bus_we_*` and `data_out` path in wrapped_as2650.

## Interface
- `N_IRQ`, default 8: number of request lines, 1..8. Unused high bits of every register read as 0.
- `wb_clk_i` in, 1: sole clock.
- `rst` in, 1: synchronous, active-low reset.
- `bus_cyc` in, 1: peripheral bus cycle active.
- `bus_we` in, 1: write strobe for this block; a write occurs only when `bus_cyc && bus_we`.
- `addr` in, 3: register select.
- `data_in` in, 8: write data.
- `data_out` out, 8: read data, combinational from `addr`.
- `irq_in` in, N_IRQ: request lines, already synchronous to `wb_clk_i`.
- `int_ack` in, 1: one-cycle pulse from the CPU when it takes the interrupt.
- `int_req` out, 1: interrupt request to the CPU.
- `int_vector` out, 8: vector byte, valid while `int_req`=1.

## Operation
- **Register map:**
  - 0 PEND: read pending; write-1-to-clear, effective on edge lines only.
  - 1 MASK: 1 = enabled.
  - 2 MODE: 1 = rising edge, 0 = level-high.
  - 3 VBASE: vector base.
  - 4 STATUS, read-only: bit7 = in service; bit6 = `int_req`; bits2:0 = in-service index.
  - 5 EOI: write any value.
  - 6, 7: read 0, writes ignored.
- **Edge lines:**
  - `irq_prev` is registered each cycle.
  - The PEND bit sets when `irq_in & ~irq_prev`.
  - The bit stays set until W1C or acknowledge.
- **Level lines:** the PEND bit equals the registered `irq_in` each cycle; W1C and acknowledge do not affect it.
- **Active set** = PEND & MASK.
- **Priority:** lowest index wins. `int_vector` = VBASE + 2·idx, modulo 256.
- **FSM:**
  - IDLE: if the active set ≠ 0, go to REQ.
  - REQ: `int_req`=1, and `int_vector` tracks the current winner every cycle.
    - On `int_ack`, latch the winner into the in-service index. Clear its PEND bit if it is an edge line. Go to SERVICE.
    - If the active set becomes 0 without `int_ack`, go to IDLE.
  - SERVICE: `int_req`=0. Other pending lines keep accumulating. An EOI write goes to IDLE.
- No nesting: a higher-priority line waits for EOI.
- EOI written in IDLE or REQ is ignored.
- **Reset values:** PEND=0, MASK=0, MODE=0, VBASE=0, `irq_prev`=0, state=IDLE, `int_req`=0, `int_vector`=0, STATUS=0.

## Timing
- Register writes take effect on the clock edge ending the bus cycle; the new value is visible on `data_out` the next cycle.
- **Edge detection:** rising edge seen in cycle t → PEND bit set at t+1 → REQ, `int_req`=1 at t+2. Level lines have the same latency.
- **`int_ack` in REQ:** `int_req` falls the next cycle. The vector captured is the value driven in the ack cycle.
- **`int_ack` outside REQ:** ignored.
- **Simultaneous events:**
  - Edge-set and W1C on the same bit: set wins.
  - Edge-set and acknowledge-clear on the same bit: set wins; the new request is retained.
  - `int_ack` in the same cycle the active set drops to 0: ack wins, using the vector driven that cycle.
  - MASK write in REQ: the winner is re-evaluated next cycle.
- **EOI:** IDLE the next cycle. If the active set is still ≠ 0, `int_req`=1 one cycle after that.
- **Reset mid-operation:** any state → IDLE with all outputs 0 the cycle after `rst`=0. The in-service index is lost.

## Structure
- Package `irq_ctrl_pkg`:
  - register address localparams (`IRQ_PEND`..`IRQ_EOI`)
  - state enum `irq_state_t` {IDLE, REQ, SERVICE}
  - STATUS bit positions.
- Sub-module `prio_enc8`: 8-bit input → `valid` + 3-bit lowest-set index, purely combinational, instantiated once.
- Top-level placement: `irq_ctrl` takes the concatenation of irq0..irq7 in the top level. Line 4 is tied to 0.

## Test plan
- **Reset:** assert `rst`=0 for 2 cycles with `irq_in`=8'hFF → `int_req`=0, `int_vector`=0, all registers read 0.
- **Single edge interrupt:** MASK=8'h08, MODE=8'h08, VBASE=8'h40, pulse `irq_in[3]` in cycle t → `int_req`=1 at t+2 with `int_vector`=8'h46. Then `int_ack` → `int_req`=0 next cycle, STATUS=8'h83, PEND=0.
- **Priority:**
  - MASK=8'hFF, MODE=8'hFF, edges on lines 5 and 2 in the same cycle → vector VBASE+4.
  - After ack and EOI → second request with vector VBASE+10.
- **Level line:** MODE=0, MASK=8'h01, hold `irq_in[0]`=1 → W1C to PEND has no effect. Ack, deassert the line, EOI → `int_req` stays 0.
- **Collisions:**
  - W1C of bit 1 in the same cycle as an edge on line 1 → PEND[1] stays 1.
  - Mask-off in REQ → IDLE next cycle, `int_req`=0.
  - EOI in IDLE → no state change.
- **Reset mid-SERVICE:** line 6 in service, assert `rst`=0 → STATUS=0, IDLE, a new edge on line 6 is serviced normally with latency 2.
